// File: rtl/i2c_mem_ctrl.sv
// I2C slave-side memory controller: two address bytes set an auto-incrementing
// pointer, then written bytes are stored and read requests fetch bytes from memory.
module i2c_mem_ctrl #(
    parameter int ADDR_W  = 14,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2c_start,
    input  logic              i2c_rw,
    input  logic              i2c_stop,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_req,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W-1:0] addr_ptr,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR_HI  = 3'd1,
        ADDR_LO  = 3'd2,
        WR_DATA  = 3'd3,
        RD_READY = 3'd4,
        RD_PEND  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-9:0] hi_q, hi_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              ce_q, ce_d;
    logic              wre_q, wre_d;
    logic [1:0]        cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hi_q       <= '0;
            ptr_q      <= '0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ce_q       <= 1'b0;
            wre_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            ptr_q      <= ptr_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            ce_q       <= ce_d;
            wre_q      <= wre_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        ptr_d      = ptr_q;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        ce_d       = 1'b0;
        wre_d      = 1'b0;
        cnt_d      = cnt_q;
        // START beats STOP and any byte event in the same cycle; leaving RD_PEND drops the read.
        if (i2c_start) begin
            state_d = i2c_rw ? RD_READY : ADDR_HI;
            cnt_d   = '0;
        end else if (i2c_stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ADDR_HI: if (rx_valid) begin
                    hi_d    = rx_data[ADDR_W-9:0];
                    state_d = ADDR_LO;
                end
                ADDR_LO: if (rx_valid) begin
                    ptr_d   = {hi_q, rx_data};
                    state_d = WR_DATA;
                end
                WR_DATA: if (rx_valid) begin
                    ce_d    = 1'b1;
                    wre_d   = 1'b1;
                    maddr_d = ptr_q;
                    wdata_d = rx_data;
                    ptr_d   = ptr_q + ADDR_W'(1);
                end
                RD_READY: if (tx_req) begin
                    ce_d    = 1'b1;
                    maddr_d = ptr_q;
                    ptr_d   = ptr_q + ADDR_W'(1);
                    cnt_d   = '0;
                    state_d = RD_PEND;
                end
                RD_PEND: begin
                    // cnt_q counts cycles since the ce cycle; data is valid at MEM_LAT.
                    if (cnt_q == 2'(MEM_LAT)) begin
                        tx_data_d  = mem_rdata;
                        tx_valid_d = 1'b1;
                        state_d    = RD_READY;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign mem_ce    = ce_q;
    assign mem_wre   = wre_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign addr_ptr  = ptr_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_i2c_mem_ctrl.sv
// Scoreboard bench for i2c_mem_ctrl: directed I2C transactions push expected
// memory accesses and read bytes; a negedge monitor pops and compares them.
module tb_i2c_mem_ctrl;
  localparam int ADDR_W  = 14;
  localparam int MEM_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              i2c_start, i2c_rw, i2c_stop, rx_valid, tx_req;
  logic [7:0]        rx_data;
  logic              tx_valid, mem_ce, mem_wre, busy;
  logic [7:0]        tx_data, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr, addr_ptr;
  logic [2:0]        state_dbg;

  int unsigned cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  // exp_wr_q: {addr, data}; exp_rce_q: {cycle, addr}; exp_rd_q: {cycle, data}
  logic [21:0] exp_wr_q[$];
  logic [45:0] exp_rce_q[$];
  logic [39:0] exp_rd_q[$];

  i2c_mem_ctrl #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .i2c_start(i2c_start), .i2c_rw(i2c_rw),
    .i2c_stop(i2c_stop), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_req(tx_req), .tx_valid(tx_valid), .tx_data(tx_data),
    .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .addr_ptr(addr_ptr),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model with MEM_LAT-cycle read latency
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] rd1, rd2;
  always @(posedge clk) begin
    if (mem_ce === 1'b1 && mem_wre === 1'b1) mem[mem_addr] <= mem_wdata;
    if (mem_ce === 1'b1 && mem_wre === 1'b0) rd1 <= mem[mem_addr];
    rd2 <= rd1;
  end
  assign mem_rdata = (MEM_LAT == 2) ? rd2 : rd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor
  always @(negedge clk) begin
    if (mem_ce === 1'b1 && mem_wre === 1'b1) begin
      if (exp_wr_q.size() == 0) check("unexpected_write", {10'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      else check("write", {10'd0, mem_addr, mem_wdata}, {10'd0, exp_wr_q.pop_front()});
    end
    if (mem_ce === 1'b1 && mem_wre === 1'b0) begin
      if (exp_rce_q.size() == 0) check("unexpected_read_ce", {18'd0, mem_addr}, 32'hFFFF_FFFF);
      else begin
        logic [45:0] e;
        e = exp_rce_q.pop_front();
        check("read_ce_cycle", cyc, e[45:14]);
        check("read_ce_addr", {18'd0, mem_addr}, {18'd0, e[13:0]});
      end
    end
    if (tx_valid === 1'b1) begin
      if (exp_rd_q.size() == 0) check("unexpected_tx_valid", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else begin
        logic [39:0] e;
        e = exp_rd_q.pop_front();
        check("tx_valid_cycle", cyc, e[39:8]);
        check("tx_data", {24'd0, tx_data}, {24'd0, e[7:0]});
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic rw);
    step(); i2c_start = 1'b1; i2c_rw = rw;
    step(); i2c_start = 1'b0; i2c_rw = 1'b0;
  endtask

  task automatic do_stop();
    step(); i2c_stop = 1'b1;
    step(); i2c_stop = 1'b0;
  endtask

  task automatic do_rx(input logic [7:0] d);
    step(); rx_valid = 1'b1; rx_data = d;
    step(); rx_valid = 1'b0;
  endtask

  task automatic do_write(input logic [13:0] a, input logic [7:0] d);
    exp_wr_q.push_back({a, d});
    do_rx(d);
  endtask

  task automatic do_read(input logic [13:0] a, input logic [7:0] d);
    step(); tx_req = 1'b1;
    exp_rce_q.push_back({cyc + 32'd1, a});
    exp_rd_q.push_back({cyc + 32'd2 + 32'(MEM_LAT), d});
    step(); tx_req = 1'b0;
    repeat (5) step();
  endtask

  task automatic check_ptr(input string name, input logic [13:0] exp);
    @(negedge clk);
    check(name, {18'd0, addr_ptr}, {18'd0, exp});
  endtask

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    check({tag, "_mem_ce"}, {31'd0, mem_ce}, 32'd0);
    check({tag, "_mem_wre"}, {31'd0, mem_wre}, 32'd0);
    check({tag, "_mem_addr"}, {18'd0, mem_addr}, 32'd0);
    check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
    check({tag, "_addr_ptr"}, {18'd0, addr_ptr}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; i2c_start = 1'b0; i2c_rw = 1'b0; i2c_stop = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; tx_req = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    step(); rst = 1'b0;

    // write 0xA5@0x1234, 0x5A@0x1235
    do_start(1'b0);
    do_rx(8'h12);
    do_rx(8'h34);
    check_ptr("ptr_after_addr", 14'h1234);
    do_write(14'h1234, 8'hA5);
    do_write(14'h1235, 8'h5A);
    do_stop();
    check_ptr("ptr_after_write", 14'h1236);
    check("busy_after_stop", {31'd0, busy}, 32'd0);

    // read back via repeated START
    do_start(1'b0);
    do_rx(8'h12);
    do_rx(8'h34);
    do_start(1'b1);
    do_read(14'h1234, 8'hA5);
    do_read(14'h1235, 8'h5A);
    do_stop();
    check_ptr("ptr_after_read", 14'h1236);

    // wrap at 0x3FFF
    do_start(1'b0);
    do_rx(8'h3F);
    do_rx(8'hFF);
    do_write(14'h3FFF, 8'h11);
    do_write(14'h0000, 8'h22);
    do_stop();
    check_ptr("ptr_after_wrap", 14'h0001);

    // wrap read back, upper high-byte bits ignored (0xFF -> 0x3F)
    do_start(1'b0);
    do_rx(8'hFF);
    do_rx(8'hFF);
    do_start(1'b1);
    do_read(14'h3FFF, 8'h11);
    do_read(14'h0000, 8'h22);
    do_stop();
    check_ptr("ptr_after_wrap_read", 14'h0001);

    // stop after one address byte
    do_start(1'b0);
    do_rx(8'h05);
    do_stop();
    check_ptr("ptr_after_addr_abort", 14'h0001);

    // stop one cycle after tx_req
    do_start(1'b1);
    step(); tx_req = 1'b1;
    exp_rce_q.push_back({cyc + 32'd1, 14'h0001});
    step(); tx_req = 1'b0; i2c_stop = 1'b1;
    step(); i2c_stop = 1'b0;
    repeat (5) step();
    check_ptr("ptr_after_rd_abort", 14'h0002);
    check("busy_after_rd_abort", {31'd0, busy}, 32'd0);

    // start+stop collision -> ADDR_HI, then write 0x77@0x0002
    step(); i2c_start = 1'b1; i2c_rw = 1'b0; i2c_stop = 1'b1;
    step(); i2c_start = 1'b0; i2c_stop = 1'b0;
    @(negedge clk);
    check("busy_start_stop", {31'd0, busy}, 32'd1);
    do_rx(8'h00);
    do_rx(8'h02);
    do_write(14'h0002, 8'h77);
    do_start(1'b0);
    do_rx(8'h00);
    do_rx(8'h02);
    do_start(1'b1);
    // tx_req held through RD_PEND: second request ignored
    step(); tx_req = 1'b1;
    exp_rce_q.push_back({cyc + 32'd1, 14'h0002});
    exp_rd_q.push_back({cyc + 32'd2 + 32'(MEM_LAT), 8'h77});
    step();
    step(); tx_req = 1'b0;
    repeat (5) step();
    check_ptr("ptr_after_pend_req", 14'h0003);

    // reset during RD_PEND
    step(); tx_req = 1'b1;
    exp_rce_q.push_back({cyc + 32'd1, 14'h0003});
    step(); tx_req = 1'b0; rst = 1'b1;
    step(); rst = 1'b0;
    check_all_zero("post_rst");
    repeat (6) step();
    check("busy_idle_after_rst", {31'd0, busy}, 32'd0);

    repeat (10) step();
    check("wr_q_empty", exp_wr_q.size(), 32'd0);
    check("rce_q_empty", exp_rce_q.size(), 32'd0);
    check("rd_q_empty", exp_rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
